mem_bus_bridge: RTL

- Sits between the multicycle data path's memory port and an external byte-wide memory that has variable latency and uses a req/ack handshake.
- Replaces the combinational single-cycle memory model. It stalls the controller while an access is outstanding.
- Latches the read byte and presents it stably to IR/TR/data consumers.
- Enforces a bus timeout with a sticky error flag.

---
 rtl/mem_bridge_pkg.sv | 19 +
 rtl/bridge_timeout_counter.sv | 28 ++
 rtl/gen_reg.sv | 18 +
 rtl/mem_bus_bridge.sv | 114 +++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared types and defaults for the memory bus bridge.
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam int          ADDR_W_DEF     = 13;
    localparam int          DATA_W_DEF     = 8;
    localparam logic [7:0]  ABORT_DATA_DEF = 8'hFF;

    // Counter only needs to reach TIMEOUT-1; the +1 keeps width >= 1 for TIMEOUT = 1.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/bridge_timeout_counter.sv
// Counts ACCESS cycles; tc flags the last cycle allowed before an abort.
module bridge_timeout_counter
    import mem_bridge_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int            CW   = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Clear has priority; the FSM leaves ACCESS at LAST so no wrap is needed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/gen_reg.sv
// Generic enabled register with asynchronous active-low clear.
module gen_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load on enable, hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/mem_bus_bridge.sv
// Bridges the data-path memory port to a variable-latency req/ack byte bus,
// stalling the controller and aborting with a sticky error on timeout.
module mem_bus_bridge
    import mem_bridge_pkg::*;
#(
    parameter int              ADDR_W     = ADDR_W_DEF,
    parameter int              DATA_W     = DATA_W_DEF,
    parameter int              TIMEOUT    = 15,
    parameter logic [DATA_W-1:0] ABORT_DATA = DATA_W'(ABORT_DATA_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_read,
    input  logic              cpu_write,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_done,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              err,
    input  logic              err_clr
);

    state_t state, state_nxt;
    logic   load;
    logic   tc;
    logic   in_access;
    logic   to_abort;
    logic   hold_we;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next state and controller-facing strobes.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        cpu_stall = 1'b0;
        cpu_done  = 1'b0;
        bus_req   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cpu_stall = cpu_read | cpu_write;
                if (cpu_read | cpu_write) begin
                    load      = 1'b1;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cpu_stall = 1'b1;
                bus_req   = 1'b1;
                if (bus_ack || tc) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                cpu_done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign in_access = (state == ST_ACCESS);
    // A coincident ack wins over the timeout.
    assign to_abort  = in_access && !bus_ack && tc;

    // Holding registers: bus side sees only these, never the live cpu inputs.
    gen_reg #(.W(ADDR_W)) u_addr_reg (
        .clk (clk), .rst (rst), .en (load), .d (cpu_addr),  .q (bus_addr)
    );
    gen_reg #(.W(DATA_W)) u_wdata_reg (
        .clk (clk), .rst (rst), .en (load), .d (cpu_wdata), .q (bus_wdata)
    );
    // Write wins when read and write are both requested.
    gen_reg #(.W(1)) u_we_reg (
        .clk (clk), .rst (rst), .en (load), .d (cpu_write), .q (hold_we)
    );

    assign bus_we = hold_we;

    bridge_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk (clk),
        .rst (rst),
        .clr (load),
        .en  (in_access),
        .tc  (tc)
    );

    // Read data latch: ack data on success, abort pattern on timeout, else hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata <= '0;
        end else if (in_access && !hold_we) begin
            if (bus_ack)  cpu_rdata <= bus_rdata;
            else if (tc)  cpu_rdata <= ABORT_DATA;
        end
    end

    // Sticky timeout flag; a new abort beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         err <= 1'b0;
        else if (to_abort) err <= 1'b1;
        else if (err_clr)  err <= 1'b0;
    end

endmodule
